rr_reg_arbiter: RTL
===================

// Module: rr_reg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one registered (flip-flop) output stage among NUM_REQ
//  valid/ready requesters. The winning requester's word is captured in the output register
//  and held until downstream accepts it. Sits in front of any single-port consumer that
//  multiple sources share; gives one word/cycle throughput with fair, starvation-free access.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=1)
//  DATA_WIDTH  32  width of each data word
//  SRC_W       derived: (NUM_REQ>1) ? $clog2(NUM_REQ) : 1
// PORTS
//  clk_i        in   1                    clock; all logic on rising edge
//  rstn_i       in   1                    reset, asynchronous, active-low
//  req_valid_i  in   NUM_REQ              per-requester valid
//  req_data_i   in   NUM_REQ*DATA_WIDTH   packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready_o  out  NUM_REQ              per-requester ready (one-hot or zero)
//  out_valid_o  out  1                    output register holds a word
//  out_data_o   out  DATA_WIDTH           registered data
//  out_src_o    out  SRC_W                index of requester that supplied out_data_o
//  out_ready_i  in   1                    downstream accepts word when out_valid_o & out_ready_i
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (clk_i, rstn_i).
//  - Reset values: out_valid_o=0, out_data_o=0, out_src_o=0, rr pointer ptr=0;
//    req_ready_o=0 while rstn_i low. Reset mid-operation discards any held word.
//  - Output register state: EMPTY (out_valid_o=0) / FULL (out_valid_o=1).
//    load_en = !out_valid_o | out_ready_i (empty, or draining this cycle).
//  - Arbitration (combinational): scan i = ptr, ptr+1, ... mod NUM_REQ; first i with
//    req_valid_i[i]=1 is granted. req_ready_o[i] = load_en & grant[i]; never more than one bit set.
//  - Transfer from requester i occurs on a clock edge where req_valid_i[i] & req_ready_o[i]:
//    out_data_o <= data_i, out_src_o <= i, out_valid_o <= 1, ptr <= (i+1) mod NUM_REQ.
//  - No grant and out_ready_i & out_valid_o: out_valid_o <= 0, out_data_o/out_src_o hold.
//  - Simultaneous drain + load: register takes new word, out_valid_o stays 1 (no bubble).
//  - FULL and out_ready_i=0: out_data_o/out_src_o/out_valid_o stable; all req_ready_o=0; ptr holds.
//  - Latency: accepted word appears on out_* the cycle after the transfer edge (1 cycle).
//  - ptr changes only on a transfer; wrap NUM_REQ-1 -> 0. Idle requesters do not move ptr.
//  - req_ready_o depends on req_valid_i and out_ready_i combinationally; it does not depend
//    on req_data_i. Requesters hold valid and data stable until accepted.
//  - NUM_REQ=1: degenerates to a single registered valid/ready stage, out_src_o=0.
//  - Fairness: a continuously requesting source waits at most NUM_REQ-1 transfers.
// TESTING
//  1 Reset: rstn_i=0 mid-run with out_valid_o=1 -> out_valid_o=0, out_data_o=0, out_src_o=0,
//    req_ready_o=0 immediately (async); after release first grant goes to requester 0.
//  2 Single source: NUM_REQ=4, req 2 sends 0xAAAA0000..0xAAAA0002 back-to-back, out_ready_i=1
//    -> out_data_o shows each word one cycle after its transfer, out_src_o=2, no bubbles.
//  3 Round robin: all 4 valid continuously with data 0x1000_000i, out_ready_i=1
//    -> out_src_o sequence 0,1,2,3,0,1,... each requester accepted once per 4 cycles.
//  4 Backpressure: FULL with 0xBEEF0001, out_ready_i=0 for 3 cycles -> out_data_o/out_src_o stable,
//    req_ready_o=0; on out_ready_i=1 next word loads same cycle, out_valid_o stays 1.
//  5 Pointer wrap/skip: ptr=3, only req 1 valid -> req 1 granted, ptr becomes 2; then req 3 and
//    req 1 valid -> req 3 granted first, ptr wraps to 0.
//  6 Drain to empty: FULL, no req valid, out_ready_i=1 -> out_valid_o=0 next cycle, data held.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_reg_arbiter
// Brief   : Round-robin arbiter feeding one registered valid/ready output stage.
// Revision: 1.0
// ============================================================================
module rr_reg_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [SRC_W-1:0]              out_src_o,
    input  logic                          out_ready_i
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SRC_W-1:0]        r_ptr;
    logic [SRC_W-1:0]        r_src;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_load_en;
    logic                    w_load;
    logic                    w_any;
    logic [SRC_W-1:0]        w_grant_idx;
    logic [NUM_REQ-1:0]      w_grant;
    logic [DATA_WIDTH-1:0]   w_req_data [NUM_REQ];

    // Requester index reached by stepping 'off' places from 'base', modulo NUM_REQ.
    function automatic logic [SRC_W-1:0] f_wrap(input logic [SRC_W-1:0] base, input int off);
        int v;
        v = int'(base) + off;
        if (v >= NUM_REQ) begin
            v = v - NUM_REQ;
        end
        return v[SRC_W-1:0];
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_data[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after the pointer wins.
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid_i[f_wrap(r_ptr, k)]) begin
                w_any       = 1'b1;
                w_grant_idx = f_wrap(r_ptr, k);
            end
        end
        w_grant = w_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
    end

    assign w_load_en   = (r_state == ST_EMPTY) | out_ready_i;
    assign w_load      = w_load_en & w_any;
    assign req_ready_o = (rstn_i & w_load_en) ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end else if (out_ready_i) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data/source hold across a drain; only a transfer rewrites them or moves the pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_load) begin
            r_data <= w_req_data[w_grant_idx];
            r_src  <= w_grant_idx;
            r_ptr  <= f_wrap(w_grant_idx, 1);
        end
    end

    assign out_valid_o = (r_state == ST_FULL);
    assign out_data_o  = r_data;
    assign out_src_o   = r_src;

endmodule
`default_nettype wire
